arrow_shot_ctrl: RTL and testbench
==================================

ARROW_SHOT_CTRL -- requirements
Module: arrow_shot_ctrl

Interface
REQ-001 SHALL have parameters: HEAD_W 24 arrow-head bitmap width (px); HEAD_H 32 arrow-head bitmap height (px); FLOOR_Y 400 launch base row; CEIL_Y 16 ceiling row; SPEED 4 px rise per frame; STICK_FRAMES 30 ceiling hold frames.
REQ-002 SHALL have ports: clk in 1 system clock; resetN in 1 reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports: startOfFrame in 1 one-cycle frame pulse; fire in 1 shoot request pulse; playerX in 11 arrow left column at launch; pixelX in 11, pixelY in 11 current scan pixel; collision in 1 arrow-hit pulse.
REQ-004 SHALL have ports: offsetX out 11, offsetY out 11 bitmap offsets; InsideRectangle out 1 pixel inside arrow region; arrowActive out 1 arrow in flight/stuck; tipY out 11 arrow top row.

Function
REQ-005 SHALL implement FSM IDLE, ARMED, FLY, STUCK; arrowActive=1 only in FLY and STUCK.
REQ-006 IDLE: fire=1 -> ARMED, latching playerX into arrowX; fire in any other state SHALL be ignored.
REQ-007 ARMED: on startOfFrame -> FLY, tipY=FLOOR_Y-HEAD_H (no rise that frame).
REQ-008 FLY: on each later startOfFrame, if tipY-SPEED <= CEIL_Y then tipY=CEIL_Y and state -> STUCK (ARROW_STICK_EN) or IDLE; else tipY -= SPEED.
REQ-009 STUCK: frame counter loaded 0 on entry, incremented per startOfFrame; reaching STICK_FRAMES -> IDLE.
REQ-010 collision=1 in FLY or STUCK SHALL force IDLE next cycle; collision SHALL take priority over simultaneous startOfFrame; collision in IDLE/ARMED ignored.
REQ-011 tipY and arrowX SHALL change only at startOfFrame or state entry, never mid-frame otherwise.
REQ-012 Region: inside = arrowActive AND arrowX <= pixelX < arrowX+HEAD_W AND tipY <= pixelY < FLOOR_Y (11-bit unsigned compares, arrowX+HEAD_W computed 12-bit, no wrap).
REQ-013 offsetX = pixelX-arrowX; offsetY = min(pixelY-tipY, HEAD_H-1) so shaft rows repeat last bitmap row; both 0 when not inside.
REQ-014 offsetX, offsetY, InsideRectangle SHALL be registered: exactly 1 clk latency from pixelX/pixelY.
REQ-015 tipY output SHALL hold last value in IDLE; arrowActive SHALL be registered state decode, no glitches.

Reset
REQ-016 resetN=0 SHALL asynchronously force state IDLE, tipY=FLOOR_Y, arrowX=0, stick counter=0, offsetX=0, offsetY=0, InsideRectangle=0, arrowActive=0.
REQ-017 Reset mid-flight SHALL abandon arrow; first fire after release behaves as from power-up.

Configuration
REQ-018 Macro ARROW_STICK_EN defined: STUCK state and STICK_FRAMES counter compiled in per REQ-008/009.
REQ-019 ARROW_STICK_EN undefined: STUCK and counter absent; ceiling arrival -> IDLE at that startOfFrame; STICK_FRAMES unused.

Verification
REQ-020 Defaults, fire with playerX=100, then startOfFrame -> FLY, tipY=368, arrowActive=1; next startOfFrame -> tipY=364.
REQ-021 Let flight run -> after 88 rise frames tipY=16; with ARROW_STICK_EN stays 30 frames then arrowActive=0; without, arrowActive=0 at that frame.
REQ-022 tipY=364, arrowX=100, pixel (110,370) -> one cycle later InsideRectangle=1, offsetX=10, offsetY=6; pixel (110,399) -> offsetY=31; pixel (124,370) or (110,400) -> InsideRectangle=0, offsets 0.
REQ-023 collision coincident with startOfFrame in FLY -> IDLE next cycle, tipY unchanged, InsideRectangle=0; fire during FLY ignored, arrowX unchanged.
REQ-024 resetN asserted mid-FLY (no clock edge) -> outputs immediately at REQ-016 values; fire after release relaunches from tipY=368.

Source files
------------

// File: rtl/arrow_shot_ctrl.sv
// Arrow shot controller: launch, per-frame rise, optional ceiling stick, and registered bitmap region/offsets.
// Optional feature: define ARROW_STICK_EN to compile in the STUCK state and its hold-frame counter.
module arrow_shot_ctrl #(
  parameter int HEAD_W       = 24,
  parameter int HEAD_H       = 32,
  parameter int FLOOR_Y      = 400,
  parameter int CEIL_Y       = 16,
  parameter int SPEED        = 4,
  parameter int STICK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic [10:0] playerX,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        collision,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        arrowActive,
  output logic [10:0] tipY
);

`ifdef ARROW_STICK_EN
  typedef enum logic [1:0] {IDLE, ARMED, FLY, STUCK} state_t;
  localparam int CW = $clog2(STICK_FRAMES + 1);
  logic [CW-1:0] cnt, cnt_nxt;
`else
  typedef enum logic [1:0] {IDLE, ARMED, FLY} state_t;
`endif

  localparam logic [10:0] TIP_START = 11'(FLOOR_Y - HEAD_H);
  localparam logic [10:0] TIP_CEIL  = 11'(CEIL_Y);
  localparam logic [10:0] RISE      = 11'(SPEED);
  localparam logic [10:0] FLOOR     = 11'(FLOOR_Y);
  localparam logic [10:0] OFF_MAX   = 11'(HEAD_H - 1);
  localparam logic [11:0] HEAD_W12  = 12'(HEAD_W);
  // tipY - SPEED <= CEIL_Y, rearranged so the subtraction can never underflow
  localparam logic [11:0] STOP_LIM  = 12'(CEIL_Y + SPEED);

  state_t      state, state_nxt;
  logic [10:0] arrow_x, x_nxt, tip_nxt;
  logic        active_nxt;

  always_comb begin
    state_nxt = state;
    tip_nxt   = tipY;
    x_nxt     = arrow_x;
`ifdef ARROW_STICK_EN
    cnt_nxt   = cnt;
`endif
    case (state)
      IDLE: begin
        if (fire) begin
          state_nxt = ARMED;
          x_nxt     = playerX;
        end
      end
      ARMED: begin
        if (startOfFrame) begin
          state_nxt = FLY;
          tip_nxt   = TIP_START;
        end
      end
      FLY: begin
        if (collision) begin
          state_nxt = IDLE;
        end else if (startOfFrame) begin
          if ({1'b0, tipY} <= STOP_LIM) begin
            tip_nxt = TIP_CEIL;
`ifdef ARROW_STICK_EN
            state_nxt = STUCK;
            cnt_nxt   = '0;
`else
            state_nxt = IDLE;
`endif
          end else begin
            tip_nxt = tipY - RISE;
          end
        end
      end
`ifdef ARROW_STICK_EN
      STUCK: begin
        if (collision) begin
          state_nxt = IDLE;
        end else if (startOfFrame) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt_nxt == CW'(STICK_FRAMES)) state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ARROW_STICK_EN
  assign active_nxt = (state_nxt == FLY) || (state_nxt == STUCK);
`else
  assign active_nxt = (state_nxt == FLY);
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      tipY        <= FLOOR;
      arrow_x     <= '0;
      arrowActive <= 1'b0;
`ifdef ARROW_STICK_EN
      cnt         <= '0;
`endif
    end else begin
      tipY        <= tip_nxt;
      arrow_x     <= x_nxt;
      arrowActive <= active_nxt;
`ifdef ARROW_STICK_EN
      cnt         <= cnt_nxt;
`endif
    end
  end

  // Region test; rows below the bitmap repeat its last row as the shaft
  logic [11:0] x_end;
  logic [10:0] dy;
  logic        in_c;

  always_comb begin
    x_end = {1'b0, arrow_x} + HEAD_W12;
    dy    = pixelY - tipY;
    in_c  = arrowActive && (pixelX >= arrow_x) && ({1'b0, pixelX} < x_end)
            && (pixelY >= tipY) && (pixelY < FLOOR);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      InsideRectangle <= 1'b0;
      offsetX         <= '0;
      offsetY         <= '0;
    end else begin
      InsideRectangle <= in_c;
      offsetX         <= in_c ? (pixelX - arrow_x) : '0;
      offsetY         <= in_c ? ((dy > OFF_MAX) ? OFF_MAX : dy) : '0;
    end
  end

endmodule

// File: tb/tb_arrow_shot_ctrl.sv
// Randomized + directed bench for arrow_shot_ctrl against a frame-level behavioural model.
module tb_arrow_shot_ctrl;

  localparam int HEAD_W = 24, HEAD_H = 32, FLOOR_Y = 400, CEIL_Y = 16;
  localparam int SPEED = 4, STICK_FRAMES = 30;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0, fire = 1'b0, collision = 1'b0;
  logic [10:0] playerX = '0, pixelX = '0, pixelY = '0;
  logic [10:0] offsetX, offsetY, tipY;
  logic        InsideRectangle, arrowActive;

  arrow_shot_ctrl #(
    .HEAD_W(HEAD_W), .HEAD_H(HEAD_H), .FLOOR_Y(FLOOR_Y), .CEIL_Y(CEIL_Y),
    .SPEED(SPEED), .STICK_FRAMES(STICK_FRAMES)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fire(fire),
    .playerX(playerX), .pixelX(pixelX), .pixelY(pixelY), .collision(collision),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .arrowActive(arrowActive), .tipY(tipY)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: an arrow is waiting for a frame, flying, or held at the ceiling
  bit m_waiting, m_flying, m_holding;
  int m_x, m_tip, m_held;
  int e_in, e_ox, e_oy;

  function automatic void model_reset();
    m_waiting = 0; m_flying = 0; m_holding = 0;
    m_x = 0; m_tip = FLOOR_Y; m_held = 0;
  endfunction

  function automatic void model_edge(input bit sof, input bit fr, input bit col,
                                     input int plx, input int px, input int py);
    bit visible;
    visible = m_flying || m_holding;
    e_in = (visible && px >= m_x && px < m_x + HEAD_W && py >= m_tip && py < FLOOR_Y) ? 1 : 0;
    e_ox = e_in ? px - m_x : 0;
    e_oy = e_in ? ((py - m_tip > HEAD_H - 1) ? HEAD_H - 1 : py - m_tip) : 0;
    if (visible && col) begin
      m_flying = 0; m_holding = 0;
    end else if (!visible && !m_waiting && fr) begin
      m_waiting = 1; m_x = plx;
    end else if (m_waiting && sof) begin
      m_waiting = 0; m_flying = 1; m_tip = FLOOR_Y - HEAD_H;
    end else if (m_flying && sof) begin
      if (m_tip - SPEED <= CEIL_Y) begin
        m_tip = CEIL_Y; m_flying = 0;
`ifdef ARROW_STICK_EN
        m_holding = 1; m_held = 0;
`endif
      end else begin
        m_tip = m_tip - SPEED;
      end
    end else if (m_holding && sof) begin
      m_held++;
      if (m_held == STICK_FRAMES) m_holding = 0;
    end
  endfunction

  task automatic step(input bit sof, input bit fr, input bit col,
                      input int plx, input int px, input int py);
    startOfFrame = sof; fire = fr; collision = col;
    playerX = 11'(plx); pixelX = 11'(px); pixelY = 11'(py);
    @(posedge clk);
    model_edge(sof, fr, col, plx, int'(pixelX), int'(pixelY));
    #1;
    check_val("active", int'(arrowActive), (m_flying || m_holding) ? 1 : 0);
    check_val("tipY", int'(tipY), m_tip);
    check_val("inside", int'(InsideRectangle), e_in);
    check_val("offX", int'(offsetX), e_ox);
    check_val("offY", int'(offsetY), e_oy);
  endtask

  int rises;
  int px_r;

  initial begin
    model_reset();
    #23;
    check_val("rst_tipY", int'(tipY), FLOOR_Y);
    check_val("rst_active", int'(arrowActive), 0);
    check_val("rst_inside", int'(InsideRectangle), 0);
    check_val("rst_offX", int'(offsetX), 0);
    check_val("rst_offY", int'(offsetY), 0);
    resetN = 1'b1;
    @(negedge clk);

    // launch and first rise
    step(0, 1, 0, 100, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_val("armed_inactive", int'(arrowActive), 0);
    step(1, 0, 0, 0, 0, 0);
    check_val("launch_tip", int'(tipY), 368);
    check_val("launch_active", int'(arrowActive), 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check_val("rise_tip", int'(tipY), 364);

    // region and offsets
    step(0, 0, 0, 0, 110, 370);
    check_val("r1_in", int'(InsideRectangle), 1);
    check_val("r1_ox", int'(offsetX), 10);
    check_val("r1_oy", int'(offsetY), 6);
    step(0, 0, 0, 0, 110, 399);
    check_val("r2_oy", int'(offsetY), 31);
    step(0, 0, 0, 0, 124, 370);
    check_val("r3_in", int'(InsideRectangle), 0);
    check_val("r3_ox", int'(offsetX), 0);
    step(0, 0, 0, 0, 110, 400);
    check_val("r4_in", int'(InsideRectangle), 0);
    check_val("r4_oy", int'(offsetY), 0);

    // fire ignored in flight, then collision beats startOfFrame
    step(0, 1, 0, 500, 0, 0);
    step(0, 0, 0, 0, 110, 370);
    check_val("fire_ign_ox", int'(offsetX), 10);
    step(1, 0, 1, 0, 110, 370);
    check_val("col_active", int'(arrowActive), 0);
    check_val("col_tip", int'(tipY), 364);
    step(0, 0, 0, 0, 110, 370);
    check_val("col_inside", int'(InsideRectangle), 0);

    // asynchronous reset mid-flight
    step(0, 1, 0, 100, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 110, 370);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check_val("arst_tip", int'(tipY), FLOOR_Y);
    check_val("arst_active", int'(arrowActive), 0);
    check_val("arst_inside", int'(InsideRectangle), 0);
    check_val("arst_offX", int'(offsetX), 0);
    check_val("arst_offY", int'(offsetY), 0);
    @(negedge clk);
    resetN = 1'b1;
    step(0, 1, 0, 100, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check_val("relaunch_tip", int'(tipY), 368);

    // full flight to the ceiling
    rises = 0;
    for (int i = 0; i < 200; i++) begin
      step(0, 0, 0, 0, 105, 380);
      step(1, 0, 0, 0, 0, 0);
      rises++;
      if (tipY == 11'(CEIL_Y)) break;
    end
    check_val("rise_frames", rises, 88);
    check_val("ceil_tip", int'(tipY), CEIL_Y);
`ifdef ARROW_STICK_EN
    check_val("stuck_active", int'(arrowActive), 1);
    for (int i = 1; i < STICK_FRAMES; i++) begin
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
    end
    check_val("stuck_hold29", int'(arrowActive), 1);
    step(1, 0, 0, 0, 0, 0);
    check_val("stuck_release", int'(arrowActive), 0);
`else
    check_val("ceil_release", int'(arrowActive), 0);
`endif
    check_val("idle_tip_hold", int'(tipY), CEIL_Y);

    // randomized traffic
    for (int i = 0; i < 8000; i++) begin
      px_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047))
                                         : m_x + int'($urandom_range(0, 40)) - 8;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 511) == 0,
           ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 200)),
           px_r & 2047, int'($urandom_range(0, 450)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
